dphy_word_packer: RTL and testbench

DPHY_WORD_PACKER -- requirements
Module: dphy_word_packer

---
 rtl/dphy_pkg.sv | 20 ++
 rtl/dphy_byte_shifter.sv | 31 +++
 rtl/dphy_word_packer.sv | 123 ++++++++++++
 tb/tb_dphy_word_packer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/dphy_pkg.sv
// Shared types and parameter-legality checks for the D-PHY word packer.
package dphy_pkg;

   typedef enum logic [0:0] {
      ST_ACC   = 1'b0,
      ST_FLUSH = 1'b1
   } dphy_state_e;

   localparam int LANES_MIN  = 1;
   localparam int LANES_MAX  = 8;
   localparam int OUT_NARROW = 4;
   localparam int OUT_WIDE   = 8;

   function automatic bit params_ok(input int dl, input int ob);
      return (dl >= LANES_MIN) && (dl <= LANES_MAX) &&
             ((ob == OUT_NARROW) || (ob == OUT_WIDE)) &&
             (dl <= ob);
   endfunction

endpackage

// File: rtl/dphy_byte_shifter.sv
// Merges an input beat into the residue at byte offset cnt and
// provides the merged buffer shifted down by one output word.
module dphy_byte_shifter
   import dphy_pkg::*;
#(
   parameter int DATA_LANES = 4,
   parameter int OUT_BYTES  = 4,
   parameter int RB         = OUT_BYTES + DATA_LANES - 1,
   parameter int CW         = $clog2(OUT_BYTES)
) (
   input  logic [RB*8-1:0]         res_i,
   input  logic [CW-1:0]           cnt_i,
   input  logic [DATA_LANES*8-1:0] data_i,
   output logic [RB*8-1:0]         merged_o,
   output logic [RB*8-1:0]         down_o
);

   generate
      if (!params_ok(DATA_LANES, OUT_BYTES)) begin : g_bad_params
         $error("dphy_byte_shifter: illegal DATA_LANES/OUT_BYTES");
      end
   endgenerate

   logic [RB*8-1:0] w_ins;

   // Residue bytes at and above cnt are always zero, so OR is a merge.
   assign w_ins    = {{((RB - DATA_LANES) * 8){1'b0}}, data_i};
   assign merged_o = res_i | (w_ins << {cnt_i, 3'b000});
   assign down_o   = merged_o >> (OUT_BYTES * 8);

endmodule

// File: rtl/dphy_word_packer.sv
// Packs D-PHY lane bytes into OUT_BYTES-wide words with byte enables.
// Optional word counter enabled by defining DPHY_WORD_PACKER_STATS_EN.
module dphy_word_packer
   import dphy_pkg::*;
#(
   parameter int DATA_LANES = 4,
   parameter int OUT_BYTES  = 4
) (
   input  logic                    byte_clk_i,
   input  logic                    rst_n_i,
   input  logic [DATA_LANES*8-1:0] word_data_i,
   input  logic                    valid_i,
   input  logic                    last_i,
   output logic [OUT_BYTES*8-1:0]  data_o,
   output logic [OUT_BYTES-1:0]    byte_en_o,
   output logic                    valid_o,
   output logic                    last_o,
   output logic                    err_o,
   output logic [15:0]             word_cnt_o
);

   localparam int RB = OUT_BYTES + DATA_LANES - 1;
   localparam int CW = $clog2(OUT_BYTES);
   localparam logic [4:0] DL5 = 5'(DATA_LANES);
   localparam logic [4:0] OB5 = 5'(OUT_BYTES);

   dphy_state_e         r_state;
   logic [CW-1:0]       r_cnt;
   logic [RB*8-1:0]     r_res;
   logic [RB*8-1:0]     w_merged;
   logic [RB*8-1:0]     w_down;
   logic [4:0]          w_tot;
   logic [4:0]          w_rem;
   logic [OUT_BYTES-1:0] w_tot_be;
   logic [OUT_BYTES-1:0] w_cnt_be;

   dphy_byte_shifter #(
      .DATA_LANES (DATA_LANES),
      .OUT_BYTES  (OUT_BYTES)
   ) u_shift (
      .res_i    (r_res),
      .cnt_i    (r_cnt),
      .data_i   (word_data_i),
      .merged_o (w_merged),
      .down_o   (w_down)
   );

   assign w_tot = 5'(r_cnt) + DL5;
   assign w_rem = w_tot - OB5;

   always_comb begin
      w_tot_be = '0;
      w_cnt_be = '0;
      for (int i = 0; i < OUT_BYTES; i++) begin
         w_tot_be[i] = (5'(i) < w_tot);
         w_cnt_be[i] = (5'(i) < 5'(r_cnt));
      end
   end

   always_ff @(posedge byte_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state   <= ST_ACC;
         r_cnt     <= '0;
         r_res     <= '0;
         data_o    <= '0;
         byte_en_o <= '0;
         valid_o   <= 1'b0;
         last_o    <= 1'b0;
         err_o     <= 1'b0;
      end else begin
         valid_o <= 1'b0;
         last_o  <= 1'b0;
         if (r_state == ST_FLUSH) begin
            // r_cnt holds the remainder byte count while flushing
            data_o    <= r_res[OUT_BYTES*8-1:0];
            byte_en_o <= w_cnt_be;
            valid_o   <= 1'b1;
            last_o    <= 1'b1;
            r_cnt     <= '0;
            r_res     <= '0;
            r_state   <= ST_ACC;
            if (valid_i) err_o <= 1'b1;
         end else if (valid_i) begin
            if (last_i && (w_tot <= OB5)) begin
               data_o    <= w_merged[OUT_BYTES*8-1:0];
               byte_en_o <= w_tot_be;
               valid_o   <= 1'b1;
               last_o    <= 1'b1;
               r_cnt     <= '0;
               r_res     <= '0;
            end else if (w_tot >= OB5) begin
               data_o    <= w_merged[OUT_BYTES*8-1:0];
               byte_en_o <= '1;
               valid_o   <= 1'b1;
               r_res     <= w_down;
               r_cnt     <= CW'(w_rem);
               if (last_i) r_state <= ST_FLUSH;
            end else begin
               r_res <= w_merged;
               r_cnt <= CW'(w_tot);
            end
         end
      end
   end

`ifdef DPHY_WORD_PACKER_STATS_EN
   logic        w_emit;
   logic [15:0] r_wcnt;

   assign w_emit = (r_state == ST_FLUSH) |
                   (valid_i & (last_i | (w_tot >= OB5)));

   always_ff @(posedge byte_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) r_wcnt <= '0;
      else if (w_emit) r_wcnt <= r_wcnt + 16'd1;
   end

   assign word_cnt_o = r_wcnt;
`else
   assign word_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dphy_word_packer.sv
// Self-checking bench: three packer instances against a byte-queue model.
module tb_dphy_word_packer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] din [3];
   logic [2:0]  vld;
   logic [2:0]  lst;
   logic [31:0] od  [3];
   logic [3:0]  obe [3];
   logic [2:0]  ov;
   logic [2:0]  ol;
   logic [2:0]  oe;
   logic [15:0] owc [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dphy_word_packer #(.DATA_LANES(3), .OUT_BYTES(4)) u_l3 (
      .byte_clk_i (clk),        .rst_n_i    (rst_n),
      .word_data_i(din[0][23:0]), .valid_i  (vld[0]),
      .last_i     (lst[0]),     .data_o     (od[0]),
      .byte_en_o  (obe[0]),     .valid_o    (ov[0]),
      .last_o     (ol[0]),      .err_o      (oe[0]),
      .word_cnt_o (owc[0])
   );

   dphy_word_packer #(.DATA_LANES(1), .OUT_BYTES(4)) u_l1 (
      .byte_clk_i (clk),        .rst_n_i    (rst_n),
      .word_data_i(din[1][7:0]), .valid_i   (vld[1]),
      .last_i     (lst[1]),     .data_o     (od[1]),
      .byte_en_o  (obe[1]),     .valid_o    (ov[1]),
      .last_o     (ol[1]),      .err_o      (oe[1]),
      .word_cnt_o (owc[1])
   );

   dphy_word_packer #(.DATA_LANES(2), .OUT_BYTES(4)) u_l2 (
      .byte_clk_i (clk),        .rst_n_i    (rst_n),
      .word_data_i(din[2][15:0]), .valid_i  (vld[2]),
      .last_i     (lst[2]),     .data_o     (od[2]),
      .byte_en_o  (obe[2]),     .valid_o    (ov[2]),
      .last_o     (ol[2]),      .err_o      (oe[2]),
      .word_cnt_o (owc[2])
   );

   // Reference: bytes queue up in arrival order; words leave as whole
   // OUT_BYTES chunks, or as the packet tail when a last beat arrives.
   logic [7:0]  mq [3][$];
   bit          mfl  [3];
   bit          merr [3];
   bit          mv   [3];
   bit          ml   [3];
   logic [31:0] md   [3];
   logic [3:0]  mbe  [3];
   logic [15:0] mwc  [3];

   function automatic int dl_of(input int k);
      return (k == 0) ? 3 : (k == 1) ? 1 : 2;
   endfunction

   function automatic logic [15:0] exp_wc(input int k);
`ifdef DPHY_WORD_PACKER_STATS_EN
      return mwc[k];
`else
      return (k < 0) ? mwc[0] : 16'd0;
`endif
   endfunction

   task automatic chk(input string tag, input int k,
                      input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         mq[k].delete();
         mfl[k] = 0; merr[k] = 0; mv[k] = 0; ml[k] = 0;
         md[k] = '0; mbe[k] = '0; mwc[k] = '0;
      end
   endtask

   task automatic emit(input int k, input int n, input bit last);
      md[k] = '0;
      for (int i = 0; i < n; i++) md[k][8*i +: 8] = mq[k].pop_front();
      mbe[k] = 4'((1 << n) - 1);
      mv[k]  = 1;
      ml[k]  = last;
      mwc[k] = mwc[k] + 16'd1;
   endtask

   task automatic model_edge(input int k);
      mv[k] = 0;
      ml[k] = 0;
      if (mfl[k]) begin
         if (vld[k]) merr[k] = 1;
         emit(k, mq[k].size(), 1);
         mfl[k] = 0;
      end else if (vld[k]) begin
         for (int i = 0; i < dl_of(k); i++) mq[k].push_back(din[k][8*i +: 8]);
         if (lst[k]) begin
            if (mq[k].size() <= 4) emit(k, mq[k].size(), 1);
            else begin emit(k, 4, 0); mfl[k] = 1; end
         end else if (mq[k].size() >= 4) begin
            emit(k, 4, 0);
         end
      end
   endtask

   task automatic check_all(input string tag);
      for (int k = 0; k < 3; k++) begin
         chk({tag, "_valid"}, k, ov[k],  mv[k]);
         chk({tag, "_last"},  k, ol[k],  ml[k]);
         chk({tag, "_data"},  k, od[k],  md[k]);
         chk({tag, "_be"},    k, obe[k], mbe[k]);
         chk({tag, "_err"},   k, oe[k],  merr[k]);
         chk({tag, "_wcnt"},  k, owc[k], exp_wc(k));
      end
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) model_edge(k);
      check_all(tag);
   endtask

   task automatic idle();
      vld = '0;
      lst = '0;
   endtask

   task automatic beat(input int k, input logic [63:0] d, input bit l);
      din[k] = d;
      vld[k] = 1'b1;
      lst[k] = l;
   endtask

   initial begin
      for (int k = 0; k < 3; k++) din[k] = '0;
      idle();
      model_reset();
      #12;
      check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // lanes=3 stream, lanes=1 short packet, lanes=2 exact-fit packet
      beat(0, 64'h020100, 0); beat(1, 64'hAA, 0); beat(2, 64'h1110, 0);
      tick("s1");
      beat(0, 64'h050403, 0); beat(1, 64'hBB, 0); beat(2, 64'h1312, 1);
      tick("s2");
      chk("l3_w0", 0, od[0], 32'h03020100);
      chk("l2_word", 2, od[2], 32'h13121110);
      chk("l2_last", 2, ol[2], 1'b1);
      beat(0, 64'h080706, 0); beat(1, 64'hCC, 1); vld[2] = 1'b0;
      tick("s3");
      chk("l3_w1", 0, od[0], 32'h07060504);
      chk("l1_word", 1, od[1], 32'h00CCBBAA);
      chk("l1_be", 1, obe[1], 4'b0111);
      chk("l2_noflush", 2, ov[2], 1'b0);
      beat(0, 64'h0B0A09, 0); vld[1] = 1'b0;
      tick("s4");
      chk("l3_w2", 0, od[0], 32'h0B0A0908);
      chk("l3_be", 0, obe[0], 4'b1111);
      idle();
      tick("s5");

      // overflowing last beat: full word, then remainder
      beat(0, 64'h020100, 0); tick("f1");
      beat(0, 64'h050403, 1); tick("f2");
      chk("fl_full", 0, od[0], 32'h03020100);
      chk("fl_full_last", 0, ol[0], 1'b0);
      idle(); tick("f3");
      chk("fl_rem", 0, od[0], 32'h00000504);
      chk("fl_rem_be", 0, obe[0], 4'b0011);
      chk("fl_rem_last", 0, ol[0], 1'b1);

      // beat arriving during flush is dropped and flagged
      beat(0, 64'h020100, 0); tick("e1");
      beat(0, 64'h050403, 1); tick("e2");
      beat(0, 64'hFFEEDD, 0); tick("e3");
      chk("ovr_rem", 0, od[0], 32'h00000504);
      chk("ovr_err", 0, oe[0], 1'b1);
      idle(); tick("e4");
      chk("ovr_sticky", 0, oe[0], 1'b1);

      // reset mid-word
      beat(1, 64'h11, 0); tick("r1");
      beat(1, 64'h22, 0); tick("r2");
      idle();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      beat(1, 64'h33, 0); tick("a1");
      beat(1, 64'h44, 0); tick("a2");
      beat(1, 64'h55, 0); tick("a3");
      beat(1, 64'h66, 0); tick("a4");
      chk("rst_align", 1, od[1], 32'h66554433);
`ifdef DPHY_WORD_PACKER_STATS_EN
      chk("rst_wcnt", 1, owc[1], 16'd1);
`else
      chk("rst_wcnt", 1, owc[1], 16'd0);
`endif
      idle();

      repeat (400) begin
         for (int k = 0; k < 3; k++) begin
            vld[k] = ($urandom_range(0, 3) != 0);
            lst[k] = ($urandom_range(0, 4) == 0);
            din[k] = {$urandom, $urandom};
         end
         tick("rnd");
      end
      idle();
      repeat (3) tick("drain");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
